fifo_rr_drain_arbiter: RTL and testbench

Round-robin arbiter that drains N_CH show-ahead FIFO instances into one valid/ready output stream. It owns every rdreq of those FIFOs and grants one channel at a time for bursts of up to MAX_BURST words. Each output word is tagged with its source channel. It sits between per-source fifo buffers and a single shared downstream consumer.

---
 rtl/fifo_rr_drain_arbiter_pkg.sv | 19 +
 rtl/fifo_rr_drain_arbiter_rr_pick.sv | 38 +++
 rtl/fifo_rr_drain_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_rr_drain_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_drain_arbiter_pkg.sv
// Shared types and helpers for the FIFO drain arbiters.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Bits needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_arbiter_rr_pick.sv
// Rotating-priority picker: first set request strictly after 'last', with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]             req,
  input  logic [clog2_min1(N_CH)-1:0] last,
  output logic                        found,
  output logic [clog2_min1(N_CH)-1:0] idx
);

  localparam int CH_W = clog2_min1(N_CH);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  int                base;
  int                pos;

  // Rotate the doubled request vector so the search always scans from bit 0.
  always_comb begin
    req_dbl = {req, req};
    base    = (int'(last) >= N_CH - 1) ? 0 : int'(last) + 1;
    req_rot = N_CH'(req_dbl >> base);
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        pos   = base + i;
        if (pos >= N_CH) pos = pos - N_CH;
        idx   = CH_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of N_CH show-ahead FIFOs into one tagged valid/ready stream.
module fifo_rr_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DWIDTH    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic [N_CH-1:0]             fifo_empty_i,
  input  logic [N_CH*DWIDTH-1:0]      fifo_q_i,
  output logic [N_CH-1:0]             fifo_rdreq_o,
  output logic [DWIDTH-1:0]           out_data_o,
  output logic [clog2_min1(N_CH)-1:0] out_ch_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        busy_o
);

  localparam int CH_W = clog2_min1(N_CH);
  localparam int BC_W = clog2_min1(MAX_BURST + 1);

  arb_state_t        state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   last_grant;
  logic [BC_W-1:0]   burst_cnt;

  logic [N_CH-1:0]   req_vec;
  logic              pick_found;
  logic [CH_W-1:0]   pick_idx;

  logic              load_en;
  logic              pop;
  logic              grant_empty;
  logic [DWIDTH-1:0] grant_head;

  logic              vld_p1;
  logic [DWIDTH-1:0] data_p1;
  logic [CH_W-1:0]   ch_p1;

  assign req_vec = ~fifo_empty_i;

  rr_pick #(
    .N_CH (N_CH)
  ) u_rr_pick (
    .req   (req_vec),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_empty = fifo_empty_i[grant];
  assign grant_head  = fifo_q_i[int'(grant)*DWIDTH +: DWIDTH];
  assign load_en     = !vld_p1 || out_ready_i;
  assign pop         = (state == ARB_GRANT) && load_en && !grant_empty;

  // Pop strobe: one-hot on the granted channel, held off during reset.
  always_comb begin
    fifo_rdreq_o = '0;
    if (pop && !srst_i) fifo_rdreq_o = N_CH'(1) << grant;
  end

  // Arbitration FSM: one idle cycle to pick, then a burst until limit or empty.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(N_CH - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant      <= pick_idx;
            last_grant <= pick_idx;
            burst_cnt  <= '0;
            state      <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (pop) begin
            if (burst_cnt == BC_W'(MAX_BURST - 1)) state <= ARB_IDLE;
            else burst_cnt <= burst_cnt + BC_W'(1);
          end else if (grant_empty) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Output stage: loads only when empty or being accepted, so stalls never drop or repeat.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (load_en) begin
      vld_p1 <= pop;
      if (pop) begin
        data_p1 <= grant_head;
        ch_p1   <= grant;
      end
    end
  end

  assign out_valid_o = vld_p1;
  assign out_data_o  = data_p1;
  assign out_ch_o    = ch_p1;
  assign busy_o      = (state == ARB_GRANT) || vld_p1;

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed bench for fifo_rr_drain_arbiter with behavioural show-ahead FIFOs.
module tb_fifo_rr_drain_arbiter;

  localparam int N_CH  = 4;
  localparam int DW    = 4;
  localparam int MB    = 4;
  localparam int CH_W  = 2;
  localparam int DEPTH = 64;

  logic               clk;
  logic               srst_i;
  logic [N_CH-1:0]    fifo_empty_i;
  logic [N_CH*DW-1:0] fifo_q_i;
  logic [N_CH-1:0]    fifo_rdreq_o;
  logic [DW-1:0]      out_data_o;
  logic [CH_W-1:0]    out_ch_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic               busy_o;

  fifo_rr_drain_arbiter #(
    .N_CH      (N_CH),
    .DWIDTH    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk_i        (clk),
    .srst_i       (srst_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .out_data_o   (out_data_o),
    .out_ch_o     (out_ch_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural show-ahead FIFOs
  logic [DW-1:0] mem [N_CH][DEPTH];
  int            rd_ptr [N_CH];
  int            wr_ptr [N_CH];
  logic          flush;

  for (genvar k = 0; k < N_CH; k++) begin : g_fifo
    assign fifo_empty_i[k]       = (rd_ptr[k] == wr_ptr[k]);
    assign fifo_q_i[k*DW +: DW]  = mem[k][rd_ptr[k] % DEPTH];
  end

  always @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (flush) rd_ptr[k] <= wr_ptr[k];
      else if (fifo_rdreq_o[k]) rd_ptr[k] <= rd_ptr[k] + 1;
    end
  end

  task automatic push(input int ch, input logic [DW-1:0] d);
    mem[ch][wr_ptr[ch] % DEPTH] = d;
    wr_ptr[ch] = wr_ptr[ch] + 1;
  endtask

  // Cycle counter, accepted-word log and illegal-pop monitor
  int cyc;
  int acc_ch [$];
  int acc_d  [$];
  int acc_cyc[$];
  int bad_pops;

  initial begin
    cyc      = 0;
    bad_pops = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      acc_ch.push_back(int'(out_ch_o));
      acc_d.push_back(int'(out_data_o));
      acc_cyc.push_back(cyc);
    end
    if ($countones(fifo_rdreq_o) > 1) bad_pops = bad_pops + 1;
    for (int k = 0; k < N_CH; k++) begin
      if (fifo_rdreq_o[k] === 1'b1 && fifo_empty_i[k]) bad_pops = bad_pops + 1;
    end
    if (fifo_rdreq_o != '0 && out_valid_o === 1'b1 && out_ready_i === 1'b0)
      bad_pops = bad_pops + 1;
  end

  function automatic int log_ch(input int i);
    return (i < acc_ch.size()) ? acc_ch[i] : -1;
  endfunction
  function automatic int log_d(input int i);
    return (i < acc_d.size()) ? acc_d[i] : -1;
  endfunction
  function automatic int log_cyc(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
  endfunction

  // Checking
  int n_tests;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    #1;
  endtask

  task automatic wait_acc(input string tag, input int n, input int bound);
    int c;
    c = 0;
    while (acc_ch.size() < n && c < bound) begin
      tick();
      c++;
    end
    check_val(tag, 32'(acc_ch.size() >= n), 32'd1);
  endtask

  int base;
  int k;
  int prev_c;
  int prev_len;
  int gap_exp;
  int idx;
  int t5_ch [6];
  int t5_d  [6];

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    flush       = 1'b0;
    srst_i      = 1'b1;
    out_ready_i = 1'b1;

    // 1: reset with every FIFO holding data
    for (int c = 0; c < N_CH; c++) push(c, DW'(c + 1));
    tick();
    check_val("t1_rdreq_rst0", 32'(fifo_rdreq_o), 32'd0);
    tick();
    check_val("t1_rdreq_rst1", 32'(fifo_rdreq_o), 32'd0);
    flush = 1'b1;
    tick();
    flush  = 1'b0;
    srst_i = 1'b0;
    #1;
    check_val("t1_valid", 32'(out_valid_o), 32'd0);
    check_val("t1_data",  32'(out_data_o),  32'd0);
    check_val("t1_ch",    32'(out_ch_o),    32'd0);
    check_val("t1_busy",  32'(busy_o),      32'd0);

    // 2: ch2 only, three words, ready high
    push(2, 4'hA); push(2, 4'hB); push(2, 4'hC);
    #1;
    check_val("t2_idle_rdreq", 32'(fifo_rdreq_o), 32'd0);
    tick();
    check_val("t2_pop0", 32'(fifo_rdreq_o), 32'h4);
    check_val("t2_vld0", 32'(out_valid_o), 32'd0);
    tick();
    check_val("t2_pop1",   32'(fifo_rdreq_o), 32'h4);
    check_val("t2_data_a", 32'(out_data_o),   32'hA);
    check_val("t2_ch_a",   32'(out_ch_o),     32'd2);
    tick();
    check_val("t2_pop2",   32'(fifo_rdreq_o), 32'h4);
    check_val("t2_data_b", 32'(out_data_o),   32'hB);
    tick();
    check_val("t2_release_rdreq", 32'(fifo_rdreq_o), 32'd0);
    check_val("t2_data_c",  32'(out_data_o),  32'hC);
    check_val("t2_valid_c", 32'(out_valid_o), 32'd1);
    tick();
    check_val("t2_valid_end", 32'(out_valid_o), 32'd0);
    check_val("t2_busy_end",  32'(busy_o),      32'd0);

    // 3: four channels, six words each
    do_reset();
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < 6; i++) push(c, DW'(c * 6 + i));
    base = acc_ch.size();
    wait_acc("t3_wait", base + 24, 120);
    repeat (5) tick();
    check_val("t3_count", 32'(acc_ch.size() - base), 32'd24);
    k = 0; prev_c = 0; prev_len = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int i = 0; i < ((r == 0) ? 4 : 2); i++) begin
          idx = r * 4 + i;
          check_val($sformatf("t3_ch_%0d", k),   32'(log_ch(base + k)), 32'(c));
          check_val($sformatf("t3_data_%0d", k), 32'(log_d(base + k)),  32'((c * 6 + idx) % 16));
          if (k > 0) begin
            gap_exp = (c != prev_c) ? ((prev_len == MB) ? 2 : 3) : 1;
            check_val($sformatf("t3_gap_%0d", k),
                      32'(log_cyc(base + k) - log_cyc(base + k - 1)), 32'(gap_exp));
          end
          prev_c   = c;
          prev_len = (r == 0) ? 4 : 2;
          k++;
        end
      end
    end

    // 4: backpressure in the middle of a ch1 burst
    do_reset();
    push(1, 4'h5); push(1, 4'h6); push(1, 4'h7); push(1, 4'h8);
    base = acc_ch.size();
    wait_acc("t4_wait2", base + 2, 20);
    out_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t4_stall_vld_%0d", i),   32'(out_valid_o),  32'd1);
      check_val($sformatf("t4_stall_data_%0d", i),  32'(out_data_o),   32'h7);
      check_val($sformatf("t4_stall_ch_%0d", i),    32'(out_ch_o),     32'd1);
      check_val($sformatf("t4_stall_rdreq_%0d", i), 32'(fifo_rdreq_o), 32'd0);
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    wait_acc("t4_wait4", base + 4, 20);
    repeat (4) tick();
    check_val("t4_count", 32'(acc_ch.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t4_ch_%0d", i),   32'(log_ch(base + i)), 32'd1);
      check_val($sformatf("t4_data_%0d", i), 32'(log_d(base + i)),  32'(5 + i));
    end

    // 5: ch0 one word, ch3 five words
    do_reset();
    push(0, 4'h9);
    for (int i = 0; i < 5; i++) push(3, DW'(i + 3));
    t5_ch = '{0, 3, 3, 3, 3, 3};
    t5_d  = '{9, 3, 4, 5, 6, 7};
    base = acc_ch.size();
    wait_acc("t5_wait", base + 6, 60);
    repeat (5) tick();
    check_val("t5_count", 32'(acc_ch.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("t5_ch_%0d", i),   32'(log_ch(base + i)), 32'(t5_ch[i]));
      check_val($sformatf("t5_data_%0d", i), 32'(log_d(base + i)),  32'(t5_d[i]));
    end
    check_val("t5_gap_early_release", 32'(log_cyc(base + 1) - log_cyc(base)), 32'd3);
    check_val("t5_gap_burst_limit",   32'(log_cyc(base + 5) - log_cyc(base + 4)), 32'd2);

    // 6: reset after two pops of a ch2 burst
    do_reset();
    push(2, 4'hD); push(2, 4'hE); push(2, 4'hF); push(2, 4'h1);
    base = acc_ch.size();
    wait_acc("t6_wait1", base + 1, 20);
    check_val("t6_mid_data", 32'(out_data_o), 32'hE);
    check_val("t6_mid_ch",   32'(out_ch_o),   32'd2);
    push(0, 4'h5);
    srst_i = 1'b1;
    #1;
    check_val("t6_rdreq_in_rst", 32'(fifo_rdreq_o), 32'd0);
    tick();
    srst_i = 1'b0;
    #1;
    base = acc_ch.size();
    check_val("t6_valid_after", 32'(out_valid_o), 32'd0);
    check_val("t6_busy_after",  32'(busy_o),      32'd0);
    check_val("t6_idle_rdreq",  32'(fifo_rdreq_o), 32'd0);
    tick();
    check_val("t6_first_grant", 32'(fifo_rdreq_o), 32'h1);
    wait_acc("t6_wait3", base + 3, 40);
    repeat (5) tick();
    check_val("t6_count",  32'(acc_ch.size() - base), 32'd3);
    check_val("t6_ch_0",   32'(log_ch(base)),     32'd0);
    check_val("t6_data_0", 32'(log_d(base)),      32'h5);
    check_val("t6_ch_1",   32'(log_ch(base + 1)), 32'd2);
    check_val("t6_data_1", 32'(log_d(base + 1)),  32'hF);
    check_val("t6_ch_2",   32'(log_ch(base + 2)), 32'd2);
    check_val("t6_data_2", 32'(log_d(base + 2)),  32'h1);

    // Global pop legality over the whole run
    check_val("no_illegal_pops", 32'(bad_pops), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
